unified_mem_arbiter: RTL and testbench
======================================

Name: unified_mem_arbiter

Overview:
- Single-port memory arbiter for the four-stage pipelined processor; sits between the fetch stage, the execute-stage load/store unit and one shared instruction/data memory.
- Grants one requester at a time and holds the memory transaction until the memory acknowledges.
- Returns read data to the owning requester, and completion for writes.
- Data accesses have priority. A starvation counter guarantees fetch progress. A branch flush cancels an in-flight fetch response.

Parameters:
- ADDR_W, 8, memory address width.
- DATA_W, 16, memory data width.
- STARVE_MAX, 3, consecutive data grants allowed while a fetch waits; range 1..15.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- if_req  input  1  fetch request; held with if_addr stable until if_gnt.
- if_addr  input  ADDR_W  fetch address.
- if_gnt  output  1  combinational; request accepted this cycle.
- if_rvalid  output  1  one-cycle pulse; if_rdata valid.
- if_rdata  output  DATA_W  fetched word.
- d_req  input  1  data request; held until d_gnt.
- d_we  input  1  1 = write, 0 = read.
- d_addr  input  ADDR_W  data address.
- d_wdata  input  DATA_W  write data.
- d_gnt  output  1  combinational; accepted this cycle.
- d_rvalid  output  1  one-cycle pulse; read data valid, or write completed.
- d_rdata  output  DATA_W  load data; 0 on write completion.
- flush  input  1  branch taken or redirect; cancels fetch.
- mem_req  output  1  memory access active; held until mem_ack.
- mem_we  output  1  write strobe for the active access.
- mem_addr  output  ADDR_W  latched address.
- mem_wdata  output  DATA_W  latched write data.
- mem_rdata  input  DATA_W  memory read data; valid with mem_ack.
- mem_ack  input  1  access done; may be asserted from the first mem_req cycle.

Behaviour:
- Reset (synchronous, active-high, any state):
  - Next state is IDLE.
  - All registered outputs become 0: mem_req, mem_we, mem_addr, mem_wdata, if_rvalid, if_rdata, d_rvalid, d_rdata.
  - Starvation counter and cancel flag cleared.
  - gnt outputs are 0 while reset is high.
  - Reset during BUSY abandons the access; a late mem_ack is ignored.
- FSM states: IDLE, BUSY_IF, BUSY_D.
- IDLE arbitration, evaluated each cycle:
  - Fetch is eligible when if_req=1 and flush=0.
  - If d_req=1 and (fetch not eligible, or starve_cnt < STARVE_MAX): d_gnt=1; go to BUSY_D.
  - Else if fetch eligible: if_gnt=1; go to BUSY_IF.
  - At most one gnt is asserted per cycle.
- Grant cycle actions:
  - Latch address, we and wdata into the mem_* registers.
  - mem_req=1 from the next cycle.
  - Fetch grants drive mem_we=0.
- BUSY_x: hold mem_* stable until mem_ack=1. On the ack cycle:
  - Capture mem_rdata.
  - Drop mem_req on the next cycle.
  - Return to IDLE.
- Response: in the cycle after mem_ack, the owning rvalid pulses for 1 cycle with the captured data (d_rdata=0 for writes).
  - IDLE may grant a new request in that same cycle.
  - Minimum occupancy is 2 cycles per access; latency from gnt to rvalid is 1 + ack delay + 1 cycles.
- Starvation counter (4-bit, saturating at STARVE_MAX):
  - Increments on each d_gnt while if_req=1.
  - Clears on if_gnt, or in any cycle where if_req=0.
- Flush:
  - In BUSY_IF, or in the cycle mem_ack ends BUSY_IF: set the cancel flag. The memory access still completes; if_rvalid is suppressed, and the flag then clears.
  - In IDLE: blocks the fetch grant that cycle only.
  - No effect on data accesses.
- d_req and if_req are never dropped by the arbiter. A requester deasserting req before its gnt is legal and results in no access.

Decomposition:
- Shared package pipeline_pkg holds:
  - arb_state_t enum (IDLE, BUSY_IF, BUSY_D).
  - Constants ADDR_W and DATA_W shared with the processor top.
- One natural sub-module, arb_starve_counter: saturating counter with clear and at_max flag.

Test Plan:
- Single fetch: if_req=1, if_addr=0x10, mem_ack 1 cycle after mem_req, mem_rdata=0xA5A5.
  - Expect: if_gnt at T; mem_req T+1..T+2 with addr 0x10; if_rvalid with 0xA5A5 at T+3.
- Simultaneous requests: if_req and d_req (read 0x20) both at T.
  - Expect: d_gnt first, then if_gnt in the d_rvalid cycle.
  - Data write 0x30 with wdata 0x1234: mem_we=1, mem_wdata=0x1234; d_rvalid with d_rdata=0.
- Starvation: d_req held high for 6 accesses while if_req high, STARVE_MAX=3.
  - Expect: grant order D,D,D,IF,D,D.
  - Counter clears after the IF grant.
- Flush in flight: fetch granted to 0x40; flush pulses during BUSY_IF; memory acks.
  - Expect: no if_rvalid; the next if_req is granted normally.
  - Flush concurrent with if_req in IDLE: no if_gnt that cycle.
- Wait states: mem_ack delayed 5 cycles.
  - Expect: mem_req, mem_addr and mem_wdata stable for all 5 cycles; single rvalid pulse.
- Reset mid-access: reset=1 in BUSY_D, memory acks after reset falls.
  - Expect: mem_req=0 and all outputs 0 in the next cycle; no d_rvalid; IDLE on exit from reset.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared processor-wide definitions for the unified memory arbiter.
// Contents:
//   ADDR_W / DATA_W : memory address and data widths shared with the processor top
//   STARVE_W        : width of the fetch starvation counter
//   arb_state_t     : arbiter FSM states (IDLE, BUSY_IF, BUSY_D)
package pipeline_pkg;

  localparam int ADDR_W   = 8;
  localparam int DATA_W   = 16;
  localparam int STARVE_W = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_D  = 2'd2
  } arb_state_t;

endpackage

// File: rtl/unified_mem_arbiter_if.sv
// Bus bundle between the fetch stage, the load/store unit, the arbiter and
// the shared instruction/data memory.
// Modports:
//   master : arbiter side (takes requests, drives grants/responses and the mem_* access)
//   slave  : environment side (requesters and memory)
// Signals: if_req/if_addr/if_gnt/if_rvalid/if_rdata (fetch),
//          d_req/d_we/d_addr/d_wdata/d_gnt/d_rvalid/d_rdata (data),
//          flush, mem_req/mem_we/mem_addr/mem_wdata/mem_rdata/mem_ack (memory).
interface unified_mem_arbiter_if #(
  parameter int ADDR_W = pipeline_pkg::ADDR_W,
  parameter int DATA_W = pipeline_pkg::DATA_W
);

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;

  logic              flush;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  modport master (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, flush, mem_rdata, mem_ack,
    output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           mem_req, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, flush, mem_rdata, mem_ack,
    input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           mem_req, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/arb_starve_counter.sv
// Saturating count of data grants issued while a fetch is waiting.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   clr        : clear the count (fetch granted or no fetch waiting)
//   inc        : one more data grant while fetch waits
//   at_max     : count has reached MAX, fetch must win next arbitration
module arb_starve_counter
  import pipeline_pkg::*;
#(
  parameter int MAX = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic at_max
);

  localparam logic [STARVE_W-1:0] MAX_V = STARVE_W'(MAX);

  logic [STARVE_W-1:0] cnt;

  // Clear has priority over increment; the count never passes MAX.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt <= '0;
    end else if (inc && !at_max) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign at_max = (cnt >= MAX_V);

endmodule

// File: rtl/unified_mem_arbiter.sv
// Single-port memory arbiter between instruction fetch and the load/store unit.
// Data accesses win arbitration unless fetch has been starved for STARVE_MAX
// consecutive data grants. One access is outstanding at a time; the response
// pulses on the owner's rvalid the cycle after mem_ack. A flush during an
// in-flight fetch lets the access finish but suppresses its if_rvalid.
// Ports:
//   clk   : system clock
//   reset : synchronous active-high reset
//   bus   : request/response/memory bundle (master modport)
module unified_mem_arbiter #(
  parameter int ADDR_W     = pipeline_pkg::ADDR_W,
  parameter int DATA_W     = pipeline_pkg::DATA_W,
  parameter int STARVE_MAX = 3
) (
  input logic                  clk,
  input logic                  reset,
  unified_mem_arbiter_if.master bus
);

  import pipeline_pkg::*;

  arb_state_t        state;
  arb_state_t        state_next;
  logic              fetch_elig;
  logic              grant_d;
  logic              grant_if;
  logic              at_max;
  logic              cancel;
  logic [ADDR_W-1:0] addr_sel;

  arb_starve_counter #(
    .MAX (STARVE_MAX)
  ) u_starve (
    .clk    (clk),
    .reset  (reset),
    .clr    (grant_if || !bus.if_req),
    .inc    (grant_d && bus.if_req),
    .at_max (at_max)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Grants are only issued from IDLE; a starved fetch overrides data priority.
  always_comb begin
    state_next = state;
    grant_d    = 1'b0;
    grant_if   = 1'b0;
    fetch_elig = bus.if_req && !bus.flush;
    if (!reset) begin
      case (state)
        IDLE: begin
          if (bus.d_req && (!fetch_elig || !at_max)) begin
            grant_d    = 1'b1;
            state_next = BUSY_D;
          end else if (fetch_elig) begin
            grant_if   = 1'b1;
            state_next = BUSY_IF;
          end
        end
        BUSY_IF, BUSY_D: begin
          if (bus.mem_ack) begin
            state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  assign bus.d_gnt  = grant_d;
  assign bus.if_gnt = grant_if;
  assign addr_sel   = grant_d ? bus.d_addr : bus.if_addr;

  // Access register and response path. The flush seen in the ack cycle itself
  // must also cancel, so it is ORed with the stored flag there.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.if_rvalid <= 1'b0;
      bus.if_rdata  <= '0;
      bus.d_rvalid  <= 1'b0;
      bus.d_rdata   <= '0;
      cancel        <= 1'b0;
    end else begin
      bus.if_rvalid <= 1'b0;
      bus.d_rvalid  <= 1'b0;
      if (grant_d || grant_if) begin
        bus.mem_req   <= 1'b1;
        bus.mem_we    <= grant_d && bus.d_we;
        bus.mem_addr  <= addr_sel;
        bus.mem_wdata <= grant_d ? bus.d_wdata : {DATA_W{1'b0}};
      end
      if (state == BUSY_IF) begin
        if (bus.mem_ack) begin
          bus.mem_req <= 1'b0;
          cancel      <= 1'b0;
          if (!(cancel || bus.flush)) begin
            bus.if_rvalid <= 1'b1;
            bus.if_rdata  <= bus.mem_rdata;
          end
        end else if (bus.flush) begin
          cancel <= 1'b1;
        end
      end
      if (state == BUSY_D && bus.mem_ack) begin
        bus.mem_req  <= 1'b0;
        bus.d_rvalid <= 1'b1;
        bus.d_rdata  <= bus.mem_we ? {DATA_W{1'b0}} : bus.mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Randomized self-checking bench for unified_mem_arbiter.
// The bench plays both requesters and the memory (with a backing array and
// random wait states) and predicts grants, the memory access and responses
// from a transaction-level model of the arbitration rules.
module tb_unified_mem_arbiter;

  localparam int AW   = 8;
  localparam int DW   = 16;
  localparam int SMAX = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  unified_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  unified_mem_arbiter #(
    .ADDR_W     (AW),
    .DATA_W     (DW),
    .STARVE_MAX (SMAX)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] mem_array [0:255];

  // Reference model of the outstanding access and pending responses.
  bit          m_busy;
  bit          m_owner_d;
  bit          m_we;
  bit          m_cancel;
  bit          m_just_reset = 1'b1;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  int          m_wait;
  int          m_delay;
  int          m_starve;
  bit          exp_if_rv;
  bit          exp_d_rv;
  logic [DW-1:0] exp_if_rdata;
  logic [DW-1:0] exp_d_rdata;
  bit          exp_if_gnt;
  bit          exp_d_gnt;
  bit          last_if_gnt;
  bit          last_d_gnt;
  int          if_resp_cnt;
  int          d_resp_cnt;

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs at negedge, check outputs, advance model at posedge.
  task automatic apply_stimulus(input int p_if, input int p_d, input int p_fl,
                                input bit rst, input bit force_ack);
    bit ack;
    @(negedge clk);
    reset = rst;
    if (!bus.if_req || last_if_gnt) begin
      bus.if_req  = ($urandom_range(99) < p_if);
      bus.if_addr = AW'($urandom);
    end else if ($urandom_range(99) < 3) begin
      bus.if_req = 1'b0;
    end
    if (!bus.d_req || last_d_gnt) begin
      bus.d_req   = ($urandom_range(99) < p_d);
      bus.d_we    = 1'($urandom_range(1));
      bus.d_addr  = AW'($urandom);
      bus.d_wdata = DW'($urandom);
    end else if ($urandom_range(99) < 3) begin
      bus.d_req = 1'b0;
    end
    bus.flush     = ($urandom_range(99) < p_fl);
    ack           = force_ack || (m_busy && m_wait == m_delay);
    bus.mem_ack   = ack;
    bus.mem_rdata = (ack && m_busy && !m_we) ? mem_array[m_addr] : DW'($urandom);
    #1;
    exp_if_gnt = 1'b0;
    exp_d_gnt  = 1'b0;
    if (!rst && !m_busy) begin
      if (bus.d_req && (!(bus.if_req && !bus.flush) || m_starve < SMAX)) exp_d_gnt = 1'b1;
      else if (bus.if_req && !bus.flush) exp_if_gnt = 1'b1;
    end
    check_output("if_gnt", 32'(bus.if_gnt), 32'(exp_if_gnt));
    check_output("d_gnt", 32'(bus.d_gnt), 32'(exp_d_gnt));
    check_output("mem_req", 32'(bus.mem_req), 32'(m_busy));
    if (m_busy) begin
      check_output("mem_addr", 32'(bus.mem_addr), 32'(m_addr));
      check_output("mem_we", 32'(bus.mem_we), 32'(m_we));
      if (m_we) check_output("mem_wdata", 32'(bus.mem_wdata), 32'(m_wdata));
    end
    check_output("if_rvalid", 32'(bus.if_rvalid), 32'(exp_if_rv));
    check_output("d_rvalid", 32'(bus.d_rvalid), 32'(exp_d_rv));
    if (exp_if_rv) check_output("if_rdata", 32'(bus.if_rdata), 32'(exp_if_rdata));
    if (exp_d_rv) check_output("d_rdata", 32'(bus.d_rdata), 32'(exp_d_rdata));
    if (m_just_reset) begin
      check_output("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
      check_output("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
      check_output("rst_mem_we", 32'(bus.mem_we), 32'd0);
      check_output("rst_if_rdata", 32'(bus.if_rdata), 32'd0);
      check_output("rst_d_rdata", 32'(bus.d_rdata), 32'd0);
    end
    @(posedge clk);
    if (rst) begin
      m_busy       = 1'b0;
      m_cancel     = 1'b0;
      m_starve     = 0;
      exp_if_rv    = 1'b0;
      exp_d_rv     = 1'b0;
      m_just_reset = 1'b1;
    end else begin
      m_just_reset = 1'b0;
      exp_if_rv    = 1'b0;
      exp_d_rv     = 1'b0;
      if (m_busy) begin
        if (ack) begin
          m_busy = 1'b0;
          if (!m_owner_d) begin
            if (!(m_cancel || bus.flush)) begin
              exp_if_rv    = 1'b1;
              exp_if_rdata = mem_array[m_addr];
              if_resp_cnt++;
            end
          end else begin
            exp_d_rv = 1'b1;
            d_resp_cnt++;
            if (m_we) begin
              exp_d_rdata       = '0;
              mem_array[m_addr] = m_wdata;
            end else begin
              exp_d_rdata = mem_array[m_addr];
            end
          end
          m_cancel = 1'b0;
        end else begin
          if (!m_owner_d && bus.flush) m_cancel = 1'b1;
          m_wait++;
        end
      end else if (exp_d_gnt || exp_if_gnt) begin
        m_busy    = 1'b1;
        m_owner_d = exp_d_gnt;
        m_we      = exp_d_gnt && bus.d_we;
        m_addr    = exp_d_gnt ? bus.d_addr : bus.if_addr;
        m_wdata   = bus.d_wdata;
        m_wait    = 0;
        m_delay   = ($urandom_range(3) == 0) ? 5 : int'($urandom_range(2));
      end
      if (!bus.if_req || exp_if_gnt) m_starve = 0;
      else if (exp_d_gnt && m_starve < SMAX) m_starve++;
    end
    last_if_gnt = exp_if_gnt;
    last_d_gnt  = exp_d_gnt;
  endtask

  initial begin
    bit found;
    for (int i = 0; i < 256; i++) mem_array[i] = DW'($urandom);
    bus.if_req    = 1'b0;
    bus.if_addr   = '0;
    bus.d_req     = 1'b0;
    bus.d_we      = 1'b0;
    bus.d_addr    = '0;
    bus.d_wdata   = '0;
    bus.flush     = 1'b0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;

    $display("[TB] reset checks");
    for (int i = 0; i < 3; i++) apply_stimulus(100, 100, 0, 1'b1, 1'b0);

    $display("[TB] saturated requests (starvation)");
    for (int i = 0; i < 80; i++) apply_stimulus(100, 100, 0, 1'b0, 1'b0);

    $display("[TB] mixed random traffic with flushes");
    for (int i = 0; i < 1500; i++) apply_stimulus(60, 60, 10, 1'b0, 1'b0);
    for (int i = 0; i < 500; i++) apply_stimulus(30, 50, 25, 1'b0, 1'b0);
    for (int i = 0; i < 300; i++) apply_stimulus(90, 20, 40, 1'b0, 1'b0);

    $display("[TB] reset during data access");
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      apply_stimulus(0, 100, 0, 1'b0, 1'b0);
      found = m_busy && m_owner_d && m_wait == 0 && m_delay > 0;
    end
    check_output("reset_setup_found", 32'(found), 32'd1);
    apply_stimulus(0, 0, 0, 1'b1, 1'b0);
    apply_stimulus(0, 0, 0, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) apply_stimulus(50, 50, 10, 1'b0, 1'b0);

    for (int i = 0; i < 20; i++) apply_stimulus(0, 0, 0, 1'b0, 1'b0);
    check_output("if_responses_seen", 32'(if_resp_cnt > 50), 32'd1);
    check_output("d_responses_seen", 32'(d_resp_cnt > 50), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
